// File: rtl/bg_frame_fetcher.sv
// Background frame prefetcher: walks the frame buffer in raster order and issues
// Avalon-MM reads only while the downstream pixel FIFO is guaranteed to have room.
module bg_frame_fetcher #(
   parameter int H_PIX      = 640,
   parameter int V_PIX      = 480,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int CNT_W      = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [ADDR_W-1:0] frame_base,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              fifo_wrreq,
   output logic [DATA_W-1:0] fifo_data,
   input  logic [CNT_W-1:0]  fifo_usedw,
   output logic              frame_done,
   output logic              busy
);
   localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
   localparam logic [ADDR_W-1:0] PIX_BYTES = ADDR_W'(DATA_W / 8);
   localparam logic [XW-1:0]     X_LAST    = XW'(H_PIX - 1);
   localparam logic [YW-1:0]     Y_LAST    = YW'(V_PIX - 1);
   localparam logic [CNT_W:0]    DEPTH     = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_DONE} state_t;

   state_t           state;
   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_nxt;
   logic [CNT_W:0]   credit_sum;
   logic             accept;
   logic             credit;
   logic             last_pix;

   assign fifo_wrreq = avm_readdatavalid;
   assign fifo_data  = avm_readdata;
   assign accept     = avm_read && !avm_waitrequest;
   assign last_pix   = (x == X_LAST) && (y == Y_LAST);

   // avm_read is registered, so the decision covers the next cycle: a read being
   // accepted now is not yet in outstanding and must be counted against the FIFO.
   assign credit_sum = {1'b0, fifo_usedw} + {1'b0, outstanding} + {{CNT_W{1'b0}}, accept};
   assign credit     = credit_sum < DEPTH;

   always_comb begin
      outstanding_nxt = outstanding;
      if (accept && !avm_readdatavalid)
         outstanding_nxt = outstanding + CNT_W'(1);
      else if (!accept && avm_readdatavalid && outstanding != '0)
         outstanding_nxt = outstanding - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         avm_read    <= 1'b0;
         avm_address <= '0;
         x           <= '0;
         y           <= '0;
         outstanding <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         outstanding <= outstanding_nxt;
         case (state)
            IDLE: begin
               if (enable) begin
                  state       <= FETCH;
                  busy        <= 1'b1;
                  avm_address <= frame_base;
                  x           <= '0;
                  y           <= '0;
                  avm_read    <= credit;
               end
            end
            FETCH: begin
               if (accept) begin
                  avm_address <= avm_address + PIX_BYTES;
                  if (x == X_LAST) begin
                     x <= '0;
                     y <= y + YW'(1);
                  end else begin
                     x <= x + XW'(1);
                  end
                  if (last_pix) begin
                     avm_read <= 1'b0;
                     state    <= WAIT_DONE;
                  end else begin
                     avm_read <= credit;
                  end
               end else if (!avm_read) begin
                  avm_read <= credit;
               end
            end
            // frame_done is raised on the edge that retires the last response, and
            // enable is sampled during the pulse to decide on a back-to-back frame.
            WAIT_DONE: begin
               if (frame_done) begin
                  frame_done <= 1'b0;
                  if (enable) begin
                     state       <= FETCH;
                     avm_address <= frame_base;
                     x           <= '0;
                     y           <= '0;
                     avm_read    <= credit;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (outstanding_nxt == '0) begin
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bg_frame_fetcher.sv
// Randomized scoreboard bench for bg_frame_fetcher: a small 4x4 frame with a
// 4-word FIFO, a latency-configurable Avalon slave and a FIFO occupancy model.
module tb_bg_frame_fetcher;
   localparam int H_PIX      = 4;
   localparam int V_PIX      = 4;
   localparam int NPIX       = H_PIX * V_PIX;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] frame_base = '0;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [15:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic        fifo_wrreq;
   logic [15:0] fifo_data;
   logic [2:0]  fifo_usedw = '0;
   logic        frame_done;
   logic        busy;

   bg_frame_fetcher #(
      .H_PIX(H_PIX), .V_PIX(V_PIX), .ADDR_W(32), .DATA_W(16),
      .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_base(frame_base),
      .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_usedw(fifo_usedw),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          due;
      logic [15:0] data;
   } rsp_t;

   rsp_t        pend[$];
   logic [31:0] exp_addr[$];
   logic [15:0] exp_data[$];

   int lat        = 2;
   bit rand_wait  = 1'b0;
   bit usedw_zero = 1'b1;
   bit drain_on   = 1'b1;
   int stall_at   = -1;
   int stall_left = 0;
   int ncyc       = 0;
   int usedw_q    = 0;

   int acc_total    = 0;
   int out_model    = 0;
   int rdv_in_frame = 0;
   int run          = 0;
   int max_run      = 0;
   int wait_cycles  = 0;
   bit exp_fd       = 1'b0;
   bit prev_hold    = 1'b0;
   bit prev_fd      = 1'b0;
   logic [31:0] prev_addr = '0;
   bit edge_en      = 1'b0;
   int edge_usedw   = 0;

   function automatic logic [15:0] mem_word(input logic [31:0] a);
      return a[15:0] ^ {a[23:16], a[31:24]} ^ 16'hA5C3;
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // A frame's expected reads are simply consecutive pixel addresses from its base.
   task automatic apply_stimulus(input logic [31:0] base);
      frame_base = base;
      for (int i = 0; i < NPIX; i++) exp_addr.push_back(base + 32'(2 * i));
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_frame_done(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_done && n < 3000);
      checks++;
      if (!frame_done) begin
         errors++;
         $display("[TB] FAIL %s timeout got frame_done=0 expected 1", name);
      end
   endtask

   task automatic randomize_modes();
      lat        = $urandom_range(1, 4);
      rand_wait  = 1'($urandom_range(0, 1));
      usedw_zero = 1'($urandom_range(0, 1));
      drain_on   = 1'b1;
   endtask

   // Slave and FIFO occupancy model: inputs change mid-cycle, responses in order.
   initial begin
      forever begin
         @(negedge clk);
         ncyc++;
         if (pend.size() > 0 && pend[0].due <= ncyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend[0].data;
            void'(pend.pop_front());
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 16'($urandom);
         end
         if (stall_left == 0 && stall_at >= 0 && avm_read && acc_total == stall_at) begin
            stall_left = 5;
            stall_at   = -1;
         end
         if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
         end else begin
            avm_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
         end
         fifo_usedw = usedw_zero ? 3'd0 : 3'(usedw_q);
         #1;
         if (rst_n && avm_read && !avm_waitrequest)
            pend.push_back('{ncyc + lat, mem_word(avm_address)});
         if (usedw_zero) begin
            usedw_q = 0;
         end else begin
            int rd;
            rd = (drain_on && usedw_q > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
            usedw_q = usedw_q + (fifo_wrreq ? 1 : 0) - rd;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         edge_en    = enable;
         edge_usedw = int'(fifo_usedw);
      end
   end

   // Monitor: pops expected addresses/data whenever the DUT issues or forwards.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            out_model    = 0;
            rdv_in_frame = 0;
            exp_fd       = 1'b0;
            prev_hold    = 1'b0;
            prev_fd      = 1'b0;
            run          = 0;
         end else begin
            bit acc;
            bit rdv;
            acc = avm_read && !avm_waitrequest;
            rdv = avm_readdatavalid;
            check_output("wrreq_passthru", fifo_wrreq, rdv);
            check_output("frame_done", frame_done, exp_fd);
            check_output("outstanding", 32'(dut.outstanding), out_model);
            check_output("credit_bound", (int'(fifo_usedw) + out_model <= FIFO_DEPTH), 1);
            if (prev_hold) begin
               check_output("hold_read", avm_read, 1);
               check_output("hold_addr", avm_address, prev_addr);
            end
            if (prev_fd && edge_en)
               check_output("b2b_first_read", avm_read, (edge_usedw < FIFO_DEPTH));
            if (acc) begin
               if (exp_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL rd_addr unexpected read got %0h expected none", avm_address);
               end else begin
                  logic [31:0] a;
                  a = exp_addr.pop_front();
                  check_output("rd_addr", avm_address, a);
                  exp_data.push_back(mem_word(a));
               end
               acc_total++;
            end
            if (rdv) begin
               if (exp_data.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL fifo_data unexpected write got %0h expected none", fifo_data);
               end else begin
                  check_output("fifo_data", fifo_data, exp_data.pop_front());
               end
               rdv_in_frame++;
            end
            exp_fd = rdv && (rdv_in_frame == NPIX);
            if (exp_fd) rdv_in_frame = 0;
            if (avm_read && avm_waitrequest) wait_cycles++;
            if (acc && rdv) begin
               run++;
               if (run > max_run) max_run = run;
            end else begin
               run = 0;
            end
            out_model = out_model + int'(acc) - int'(rdv);
            prev_hold = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            prev_fd   = frame_done;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got no completion expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int a0;
      int n;
      logic [31:0] nb;

      repeat (3) step();
      check_output("rst_avm_read", avm_read, 0);
      check_output("rst_avm_address", avm_address, 0);
      check_output("rst_frame_done", frame_done, 0);
      check_output("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();

      // Small frame, zero-wait slave, latency 2, empty FIFO, enable held.
      lat = 2;
      max_run = 0;
      apply_stimulus(32'h0000_1000);
      enable = 1'b1;
      step();
      check_output("start_read", avm_read, 1);
      check_output("start_addr", avm_address, 32'h0000_1000);
      check_output("start_busy", busy, 1);
      frame_base = $urandom;
      wait_frame_done("frame1");
      check_output("accept_rdv_overlap", (max_run >= 10), 1);
      apply_stimulus(32'h0000_1000);
      step();
      frame_base = $urandom;
      wait_frame_done("frame2");

      // Credit: FIFO never drained, latency 3.
      usedw_zero = 1'b0;
      drain_on   = 1'b0;
      lat        = 3;
      apply_stimulus({$urandom_range(0, 32'h7FFF_FFFF), 1'b0});
      a0 = acc_total;
      step();
      frame_base = $urandom;
      repeat (29) step();
      check_output("credit_accepts", acc_total - a0, 4);
      check_output("credit_read_low", avm_read, 0);
      check_output("credit_usedw", fifo_usedw, 4);
      drain_on = 1'b1;
      wait_frame_done("credit_frame");

      // Waitrequest held for 5 cycles on the 3rd read of the frame.
      usedw_zero  = 1'b1;
      lat         = 2;
      stall_at    = acc_total + 2;
      wait_cycles = 0;
      apply_stimulus(32'h0002_0000);
      step();
      frame_base = $urandom;
      wait_frame_done("stall_frame");
      check_output("stall_cycles", wait_cycles, 5);

      // enable dropped after the 3rd read: frame still completes, then idles.
      apply_stimulus(32'h0003_0100);
      a0 = acc_total;
      step();
      frame_base = $urandom;
      n = 0;
      while (acc_total - a0 < 3 && n < 200) begin
         step();
         n++;
      end
      enable = 1'b0;
      wait_frame_done("drop_frame");
      repeat (20) begin
         step();
         check_output("idle_read_low", avm_read, 0);
      end
      check_output("idle_busy", busy, 0);
      check_output("idle_no_pending", exp_addr.size(), 0);

      // Randomized frames, including bases that wrap the address space.
      for (int k = 0; k < 6; k++) begin
         randomize_modes();
         if (k == 0) usedw_zero = 1'b1;
         if (k % 2 == 1) nb = 32'hFFFF_FFF0 + 32'(2 * $urandom_range(0, 7));
         else nb = {$urandom_range(0, 32'h7FFF_FFFF), 1'b0};
         apply_stimulus(nb);
         if (k == 0) begin
            enable = 1'b1;
            step();
            check_output("restart_read", avm_read, 1);
            check_output("restart_addr", avm_address, nb);
         end else begin
            step();
         end
         frame_base = $urandom;
         wait_frame_done("rand_frame");
      end

      // Reset mid-fetch with reads in flight, then restart at a new base.
      lat        = 4;
      rand_wait  = 1'b0;
      usedw_zero = 1'b1;
      apply_stimulus(32'h0004_0000);
      n = 0;
      while (out_model < 3 && n < 200) begin
         step();
         n++;
      end
      check_output("rst_inflight", out_model, 3);
      rst_n = 1'b0;
      #1;
      check_output("arst_avm_read", avm_read, 0);
      check_output("arst_avm_address", avm_address, 0);
      check_output("arst_busy", busy, 0);
      check_output("arst_frame_done", frame_done, 0);
      check_output("arst_wrreq", fifo_wrreq, avm_readdatavalid);
      pend.delete();
      exp_addr.delete();
      exp_data.delete();
      repeat (2) step();
      lat = 2;
      apply_stimulus(32'h0005_0040);
      rst_n = 1'b1;
      step();
      check_output("post_rst_read", avm_read, 1);
      check_output("post_rst_addr", avm_address, 32'h0005_0040);
      enable = 1'b0;
      frame_base = $urandom;
      wait_frame_done("post_rst_frame");
      repeat (10) step();
      check_output("end_busy", busy, 0);
      check_output("end_addr_queue", exp_addr.size(), 0);
      check_output("end_data_queue", exp_data.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
